// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: per-source youngest-producer forwarding, late-result EX stalls,
// retire-while-stalled operand buffers, pipeline stall/flush control and a stall watchdog.
module pipeline_hazard_unit #(
   parameter int unsigned NSRC      = 2,
   parameter int unsigned P         = 2,
   parameter int unsigned AW        = 5,
   parameter int unsigned XLEN      = 64,
   parameter int unsigned STALL_TMO = 255,
   localparam int unsigned SW       = $clog2(P + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 advance_i,
   input  logic [NSRC*AW-1:0]   id_rs_i,
   input  logic [NSRC-1:0]      id_need_i,
   input  logic [NSRC*AW-1:0]   ex_rs_i,
   input  logic [NSRC-1:0]      ex_use_i,
   input  logic                 ex_vld_i,
   input  logic                 ex_wen_i,
   input  logic [AW-1:0]        ex_rd_i,
   input  logic [P-1:0]         prod_vld_i,
   input  logic [P-1:0]         prod_wen_i,
   input  logic [P-1:0]         prod_late_i,
   input  logic [P*AW-1:0]      prod_rd_i,
   input  logic [P*XLEN-1:0]    prod_data_i,
   input  logic                 redirect_i,
   input  logic                 trap_i,
   input  logic                 intp_req_i,
   output logic [NSRC*SW-1:0]   fwd_sel_o,
   output logic [NSRC*XLEN-1:0] fwd_data_o,
   output logic                 if_flush_o,
   output logic                 dont_fetch_o,
   output logic                 id_stall_o,
   output logic                 id_flush_o,
   output logic                 ex_stall_o,
   output logic                 ex_flush_o,
   output logic                 intp_en_o,
   output logic                 stall_tmo_o
);

   logic [NSRC-1:0] r_buf_vld;
   logic [XLEN-1:0] r_buf_data [NSRC];
   logic            r_intp_en;
   logic [7:0]      r_cnt;

   logic [NSRC-1:0] w_hit;
   logic [NSRC-1:0] w_late;
   logic [NSRC-1:0] w_oldest;
   logic [NSRC-1:0] w_cap;
   logic [NSRC-1:0] w_id_haz;
   logic            w_ex_stall;
   logic            w_id_stall;

   always_comb begin
      w_hit      = '0;
      w_late     = '0;
      w_oldest   = '0;
      fwd_sel_o  = '0;
      fwd_data_o = '0;
      for (int s = 0; s < int'(NSRC); s++) begin
         // Scan oldest to youngest so the youngest match overwrites.
         for (int k = int'(P) - 1; k >= 0; k--) begin
            if (ex_use_i[s] && prod_vld_i[k] && prod_wen_i[k] &&
                (prod_rd_i[k*AW +: AW] != '0) &&
                (prod_rd_i[k*AW +: AW] == ex_rs_i[s*AW +: AW])) begin
               w_hit[s]                   = 1'b1;
               w_late[s]                  = prod_late_i[k];
               w_oldest[s]                = (k == int'(P) - 1);
               fwd_sel_o[s*SW +: SW]      = SW'(k + 1);
               fwd_data_o[s*XLEN +: XLEN] = prod_data_i[k*XLEN +: XLEN];
            end
         end
         if (!w_hit[s] && r_buf_vld[s]) begin
            fwd_sel_o[s*SW +: SW]      = SW'(P + 1);
            fwd_data_o[s*XLEN +: XLEN] = r_buf_data[s];
         end
      end
   end

   always_comb begin
      w_id_haz = '0;
      for (int s = 0; s < int'(NSRC); s++) begin
         w_id_haz[s] = id_need_i[s] && (id_rs_i[s*AW +: AW] != '0) &&
                       ((ex_vld_i && ex_wen_i && (ex_rd_i == id_rs_i[s*AW +: AW])) ||
                        (prod_vld_i[0] && prod_wen_i[0] && prod_late_i[0] &&
                         (prod_rd_i[0 +: AW] == id_rs_i[s*AW +: AW])));
      end
   end

   assign w_ex_stall   = |(w_hit & w_late);
   assign w_id_stall   = w_ex_stall | (|w_id_haz);
   assign w_cap        = w_hit & w_oldest & ~w_late;

   assign ex_stall_o   = w_ex_stall;
   assign id_stall_o   = w_id_stall;
   assign intp_en_o    = r_intp_en;
   // A redirect seen while ID is stalled is dropped; ID re-presents it once unstalled.
   assign if_flush_o   = trap_i | r_intp_en | (redirect_i & ~w_id_stall);
   assign dont_fetch_o = if_flush_o | w_id_stall;
   assign id_flush_o   = r_intp_en | (w_id_stall & ~w_ex_stall);
   assign ex_flush_o   = r_intp_en | w_ex_stall;
   assign stall_tmo_o  = (r_cnt == 8'(STALL_TMO));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf_vld <= '0;
         r_intp_en <= 1'b0;
         r_cnt     <= '0;
         for (int s = 0; s < int'(NSRC); s++) begin
            r_buf_data[s] <= '0;
         end
      end else if (advance_i) begin
         r_intp_en <= intp_req_i & ~trap_i;
         if (w_id_stall) begin
            if (r_cnt != 8'(STALL_TMO)) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end else begin
            r_cnt <= '0;
         end
         for (int s = 0; s < int'(NSRC); s++) begin
            if (w_ex_stall && w_cap[s]) begin
               r_buf_vld[s]  <= 1'b1;
               r_buf_data[s] <= prod_data_i[(P-1)*XLEN +: XLEN];
            end else if (!w_ex_stall || r_intp_en) begin
               r_buf_vld[s]  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed scoreboard bench for pipeline_hazard_unit: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_unit;

   localparam int unsigned NSRC = 2;
   localparam int unsigned P    = 2;
   localparam int unsigned AW   = 5;
   localparam int unsigned XLEN = 64;
   localparam int unsigned TMO  = 3;
   localparam int unsigned SW   = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 advance;
   logic [NSRC*AW-1:0]   id_rs;
   logic [NSRC-1:0]      id_need;
   logic [NSRC*AW-1:0]   ex_rs;
   logic [NSRC-1:0]      ex_use;
   logic                 ex_vld;
   logic                 ex_wen;
   logic [AW-1:0]        ex_rd;
   logic [P-1:0]         prod_vld;
   logic [P-1:0]         prod_wen;
   logic [P-1:0]         prod_late;
   logic [P*AW-1:0]      prod_rd;
   logic [P*XLEN-1:0]    prod_data;
   logic                 redirect;
   logic                 trap;
   logic                 intp_req;
   logic [NSRC*SW-1:0]   fwd_sel;
   logic [NSRC*XLEN-1:0] fwd_data;
   logic if_flush, dont_fetch, id_stall, id_flush, ex_stall, ex_flush, intp_en, stall_tmo;

   pipeline_hazard_unit #(
      .NSRC(NSRC), .P(P), .AW(AW), .XLEN(XLEN), .STALL_TMO(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .advance_i(advance),
      .id_rs_i(id_rs), .id_need_i(id_need), .ex_rs_i(ex_rs), .ex_use_i(ex_use),
      .ex_vld_i(ex_vld), .ex_wen_i(ex_wen), .ex_rd_i(ex_rd),
      .prod_vld_i(prod_vld), .prod_wen_i(prod_wen), .prod_late_i(prod_late),
      .prod_rd_i(prod_rd), .prod_data_i(prod_data),
      .redirect_i(redirect), .trap_i(trap), .intp_req_i(intp_req),
      .fwd_sel_o(fwd_sel), .fwd_data_o(fwd_data),
      .if_flush_o(if_flush), .dont_fetch_o(dont_fetch), .id_stall_o(id_stall),
      .id_flush_o(id_flush), .ex_stall_o(ex_stall), .ex_flush_o(ex_flush),
      .intp_en_o(intp_en), .stall_tmo_o(stall_tmo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string                name;
      logic [NSRC*SW-1:0]   sel;
      logic [NSRC*XLEN-1:0] data;
      logic [7:0]           flg;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Flags packed as {if_flush, dont_fetch, id_stall, id_flush, ex_stall, ex_flush, intp_en, tmo}.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [7:0] f;
         e = q.pop_front();
         f = {if_flush, dont_fetch, id_stall, id_flush, ex_stall, ex_flush, intp_en, stall_tmo};
         n_tests++;
         if (fwd_sel !== e.sel || fwd_data !== e.data || f !== e.flg) begin
            n_fail++;
            $display("FAIL %s: got sel=%h data=%h flags=%b, expected sel=%h data=%h flags=%b",
                     e.name, fwd_sel, fwd_data, f, e.sel, e.data, e.flg);
         end
      end
   end

   task automatic chk(input string n, input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                      input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                      input logic [7:0] f);
      exp_t e;
      e.name = n;
      e.sel  = {s1, s0};
      e.data = {d1, d0};
      e.flg  = f;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      advance = 0; id_rs = '0; id_need = '0; ex_rs = '0; ex_use = '0;
      ex_vld = 0; ex_wen = 0; ex_rd = '0; prod_vld = '0; prod_wen = '0;
      prod_late = '0; prod_rd = '0; prod_data = '0; redirect = 0; trap = 0; intp_req = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 0;
      clr();
      step(); chk("reset", 0, 0, 0, 0, 8'b00000000);
      step(); rst_n = 1;

      // Forwarding priority
      step(); clr();
      ex_use = 2'b01; ex_rs[0 +: AW] = 5'd5;
      prod_vld = 2'b11; prod_wen = 2'b11; prod_rd = {5'd5, 5'd5};
      prod_data = {64'hBB, 64'hAA};
      chk("fwd_youngest", 1, 0, 64'hAA, 0, 8'b00000000);
      step(); prod_vld = 2'b10; chk("fwd_stage1", 2, 0, 64'hBB, 0, 8'b00000000);
      step(); ex_use = 2'b00;   chk("fwd_unused", 0, 0, 0, 0, 8'b00000000);
      step(); ex_use = 2'b01; ex_rs = '0; prod_vld = 2'b11; prod_rd = '0;
      chk("fwd_x0", 0, 0, 0, 0, 8'b00000000);

      // Late load stall
      step(); clr();
      prod_vld = 2'b01; prod_wen = 2'b01; prod_late = 2'b01; prod_rd[0 +: AW] = 5'd6;
      prod_data[0 +: XLEN] = 64'h66; ex_use = 2'b10; ex_rs[AW +: AW] = 5'd6;
      chk("late_stall", 0, 1, 0, 64'h66, 8'b01101100);

      // Oldest producer retires while stalled -> buffered
      step();
      ex_use = 2'b11; ex_rs[0 +: AW] = 5'd7; prod_vld = 2'b11; prod_wen = 2'b11;
      prod_rd[AW +: AW] = 5'd7; prod_data[XLEN +: XLEN] = 64'h1234; advance = 1;
      chk("stall_cap", 2, 1, 64'h1234, 64'h66, 8'b01101100);
      step(); advance = 0; prod_vld = 2'b01; prod_wen = 2'b01;
      chk("buf_hold", 3, 1, 64'h1234, 64'h66, 8'b01101100);
      step(); prod_late = 2'b00; advance = 1;
      chk("buf_release", 3, 1, 64'h1234, 64'h66, 8'b00000000);
      step(); advance = 0;
      chk("buf_clear", 0, 1, 0, 64'h66, 8'b00000000);

      // ID-stage hazards and redirect suppression
      step(); clr();
      id_need = 2'b01; id_rs[0 +: AW] = 5'd3; ex_vld = 1; ex_wen = 1; ex_rd = 5'd3; redirect = 1;
      chk("id_ex_hazard", 0, 0, 0, 0, 8'b01110000);
      step(); id_rs = '0; ex_rd = '0;
      chk("id_x0_redirect", 0, 0, 0, 0, 8'b11000000);
      step(); clr();
      id_need = 2'b01; id_rs[0 +: AW] = 5'd9; prod_vld = 2'b01; prod_wen = 2'b01;
      prod_late = 2'b01; prod_rd[0 +: AW] = 5'd9;
      chk("id_late_hazard", 0, 0, 0, 0, 8'b01110000);

      // Interrupt entry
      step(); clr(); intp_req = 1; advance = 1;
      chk("intp_req", 0, 0, 0, 0, 8'b00000000);
      step(); intp_req = 0; advance = 0; chk("intp_en", 0, 0, 0, 0, 8'b11010110);
      step(); chk("intp_hold", 0, 0, 0, 0, 8'b11010110);
      step(); advance = 1; chk("intp_adv", 0, 0, 0, 0, 8'b11010110);
      step(); intp_req = 1; trap = 1; chk("intp_trap", 0, 0, 0, 0, 8'b11000000);
      step(); clr(); chk("intp_blocked", 0, 0, 0, 0, 8'b00000000);

      // Watchdog
      step(); clr();
      id_need = 2'b01; id_rs[0 +: AW] = 5'd3; ex_vld = 1; ex_wen = 1; ex_rd = 5'd3; advance = 1;
      chk("wd_0", 0, 0, 0, 0, 8'b01110000);
      step(); advance = 0; chk("wd_1", 0, 0, 0, 0, 8'b01110000);
      step(); chk("wd_freeze", 0, 0, 0, 0, 8'b01110000);
      step(); advance = 1; chk("wd_1b", 0, 0, 0, 0, 8'b01110000);
      step(); chk("wd_2", 0, 0, 0, 0, 8'b01110000);
      step(); chk("wd_tmo", 0, 0, 0, 0, 8'b01110001);
      step(); advance = 0; chk("wd_sat", 0, 0, 0, 0, 8'b01110001);

      // Async reset mid-stall drops buffer and counter
      step();
      prod_vld = 2'b11; prod_wen = 2'b11; prod_late = 2'b01; prod_rd = {5'd7, 5'd6};
      prod_data = {64'h1234, 64'h0}; ex_use = 2'b11; ex_rs = {5'd6, 5'd7}; advance = 1;
      chk("rst_setup", 2, 1, 64'h1234, 0, 8'b01101101);
      step(); advance = 0; prod_vld = 2'b01; prod_wen = 2'b01;
      chk("rst_buf", 3, 1, 64'h1234, 0, 8'b01101101);
      step(); rst_n = 0; chk("rst_async", 0, 1, 0, 0, 8'b01101100);
      step(); rst_n = 1; clr(); chk("rst_clean", 0, 0, 0, 0, 8'b00000000);

      step(); step();
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
